// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the eightbit_computer bus transfer controller:
// op encodings, FSM state type and bus width.
package bus_xfer_pkg;

    localparam int BUS_W = 8;

    localparam logic [1:0] OP_REG = 2'd0;
    localparam logic [1:0] OP_IMM = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LATCH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Select-to-one-hot decoder with enable; all outputs are 0 while en is low.
module onehot_dec #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_bit
            assign onehot[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: REG->REG, IMM->REG and CLR over the shared tri-state bus.
// Optional BUS_XFER_CAPTURE_EN adds last_byte, the byte seen on the bus at each LATCH edge.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [SEL_W-1:0]    src_sel,
    input  logic [SEL_W-1:0]    dst_sel,
    input  logic [BUS_W-1:0]    imm_data,
    inout  wire  [BUS_W-1:0]    bus,
    output logic [NUM_REGS-1:0] reg_data_out,
    output logic [NUM_REGS-1:0] reg_data_in,
    output logic [NUM_REGS-1:0] reg_clr,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef BUS_XFER_CAPTURE_EN
    ,
    output logic [BUS_W-1:0]    last_byte
`endif
);

    // One extra bit so NUM_REGS itself is representable for the range check.
    localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

    state_t             state_q;
    logic [1:0]         op_q;
    logic [SEL_W-1:0]   src_q;
    logic [SEL_W-1:0]   dst_q;
    logic [BUS_W-1:0]   imm_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic req_valid;
    logic xfer_phase;
    logic out_en;
    logic in_en;
    logic clr_en;
    logic imm_drive;

    always_comb begin
        req_valid = 1'b1;
        if (op == OP_RSV) begin
            req_valid = 1'b0;
        end
        if ({1'b0, dst_sel} >= NUM_REGS_W) begin
            req_valid = 1'b0;
        end
        if (op == OP_REG) begin
            if (({1'b0, src_sel} >= NUM_REGS_W) || (src_sel == dst_sel)) begin
                req_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_REG;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (req_valid) begin
                            op_q    <= op;
                            src_q   <= src_sel;
                            dst_q   <= dst_sel;
                            imm_q   <= imm_data;
                            busy_q  <= 1'b1;
                            state_q <= (op == OP_CLR) ? ST_CLEAR : ST_DRIVE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_CLEAR: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes come only from registered state, so an async reset drops them at once.
    assign xfer_phase = (state_q == ST_DRIVE) || (state_q == ST_LATCH);
    assign out_en     = xfer_phase && (op_q == OP_REG);
    assign imm_drive  = xfer_phase && (op_q == OP_IMM);
    assign in_en      = (state_q == ST_LATCH);
    assign clr_en     = (state_q == ST_CLEAR);

    onehot_dec #(.SEL_W(SEL_W), .NUM_OUT(NUM_REGS)) u_dec_out (
        .en     (out_en),
        .sel    (src_q),
        .onehot (reg_data_out)
    );

    onehot_dec #(.SEL_W(SEL_W), .NUM_OUT(NUM_REGS)) u_dec_in (
        .en     (in_en),
        .sel    (dst_q),
        .onehot (reg_data_in)
    );

    onehot_dec #(.SEL_W(SEL_W), .NUM_OUT(NUM_REGS)) u_dec_clr (
        .en     (clr_en),
        .sel    (dst_q),
        .onehot (reg_clr)
    );

    assign bus  = imm_drive ? imm_q : {BUS_W{1'bz}};
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

`ifdef BUS_XFER_CAPTURE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_byte <= '0;
        end else if (state_q == ST_LATCH) begin
            last_byte <= bus;
        end
    end
`endif

endmodule
